// File: rtl/carus_sram_pkg.sv
// carus_sram_pkg: power-state encoding and sizing helpers shared by the banked SRAM array
package carus_sram_pkg;

   typedef enum logic [1:0] {ACTIVE, DRAIN, RETENTIVE, WAKE} carus_sram_state_e;

   function automatic int unsigned bank_sel_width(input int unsigned num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 0;
   endfunction

endpackage

// File: rtl/carus_sram_bank.sv
// carus_sram_bank: single-port byte-writable RAM with 1-cycle read latency
module carus_sram_bank #(
   parameter int unsigned NUM_WORDS  = 1024,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                      clk_i,
   input  logic                      en_i,
   input  logic                      we_i,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   be_i,
   output logic [DATA_WIDTH-1:0]     rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         end
      end
      if (en_i && !we_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/carus_sram_array.sv
// carus_sram_array: word-interleaved multi-bank SRAM with read pipeline and retention FSM
module carus_sram_array
   import carus_sram_pkg::*;
#(
   parameter  int unsigned NUM_WORDS     = 32'd4096,
   parameter  int unsigned DATA_WIDTH    = 32'd32,
   parameter  int unsigned NUM_BANKS     = 32'd4,
   parameter  bit          OUT_REG       = 1'b1,
   parameter  int unsigned WAKEUP_CYCLES = 32'd4,
   localparam int unsigned AddrWidth     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int unsigned BeWidth       = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic                  we_i,
   input  logic [AddrWidth-1:0]  addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BeWidth-1:0]    be_i,
   input  logic                  set_retentive_ni,
   output logic                  ret_ack_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned BankSelW = bank_sel_width(NUM_BANKS);
   localparam int unsigned BankIdxW = (BankSelW > 0) ? BankSelW : 1;
   localparam int unsigned RowWords = NUM_WORDS / NUM_BANKS;
   localparam int unsigned RowW     = (RowWords > 1) ? $clog2(RowWords) : 1;
   localparam int unsigned CntW     = (WAKEUP_CYCLES > 0) ? $clog2(WAKEUP_CYCLES + 1) : 1;

   carus_sram_state_e     state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  ret_ack_q, ret_ack_d;
   logic                  vld_q, vld_d;
   logic [BankIdxW-1:0]   bidx_q, bidx_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [BankIdxW-1:0]   bank_sel;
   logic [RowW-1:0]       row;
   logic [NUM_BANKS-1:0]  bank_en;
   logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
   logic                  pending;

   // low address bits pick the bank so consecutive words land in different banks
   assign bank_sel = BankIdxW'(addr_i & AddrWidth'(NUM_BANKS - 1));
   assign row      = RowW'(addr_i >> BankSelW);
   assign gnt_o    = req_i && (state_q == ACTIVE) && set_retentive_ni && (state_q != DRAIN);

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign bank_en[b] = gnt_o && (bank_sel == BankIdxW'(b));
      carus_sram_bank #(
         .NUM_WORDS  (RowWords),
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (RowW)
      ) u_bank (
         .clk_i   (clk_i),
         .en_i    (bank_en[b]),
         .we_i    (we_i),
         .addr_i  (row),
         .wdata_i (wdata_i),
         .be_i    (be_i),
         .rdata_o (bank_rdata[b])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ACTIVE:    if (!set_retentive_ni) state_d = pending ? DRAIN : RETENTIVE;
         DRAIN:     if (!pending) state_d = RETENTIVE;
         RETENTIVE: if (set_retentive_ni) begin
            state_d = WAKE;
            cnt_d   = CntW'(WAKEUP_CYCLES);
         end
         WAKE: begin
            if (!set_retentive_ni) state_d = RETENTIVE;
            else if (cnt_q <= CntW'(1)) begin
               state_d = ACTIVE;
               cnt_d   = '0;
            end else cnt_d = cnt_q - 1'b1;
         end
         default: state_d = ACTIVE;
      endcase
      ret_ack_d = (state_d == RETENTIVE);
      vld_d     = gnt_o && !we_i;
      bidx_d    = bank_sel;
      rdata_d   = vld_q ? bank_rdata[bidx_q] : rdata_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ACTIVE;
         cnt_q     <= '0;
         ret_ack_q <= 1'b0;
         vld_q     <= 1'b0;
         bidx_q    <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ret_ack_q <= ret_ack_d;
         vld_q     <= vld_d;
         bidx_q    <= bidx_d;
         rdata_q   <= rdata_d;
      end
   end

   // with the output stage, a read sitting at the bank outputs is still owed an rvalid
   if (OUT_REG) begin : g_out_reg
      logic rvalid_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) rvalid_q <= 1'b0;
         else rvalid_q <= vld_q;
      end
      assign rvalid_o = rvalid_q;
      assign rdata_o  = rdata_q;
      assign pending  = vld_q;
   end else begin : g_out_comb
      assign rvalid_o = vld_q;
      assign rdata_o  = rdata_d;
      assign pending  = 1'b0;
   end

   assign ret_ack_o = ret_ack_q;

endmodule

// File: tb/tb_carus_sram_array.sv
// tb_carus_sram_array: randomized and directed checks of the banked SRAM against an array model
module tb_carus_sram_array;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [11:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  be_i = '0;
   logic        set_retentive_ni = 1'b1;
   logic        gnt_o, ret_ack_o, rvalid_o;
   logic [31:0] rdata_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] ref_mem [4096];
   logic [31:0] last_rd = '0;

   always #5 clk_i = ~clk_i;

   carus_sram_array dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .req_i            (req_i),
      .gnt_o            (gnt_o),
      .we_i             (we_i),
      .addr_i           (addr_i),
      .wdata_i          (wdata_i),
      .be_i             (be_i),
      .set_retentive_ni (set_retentive_ni),
      .ret_ack_o        (ret_ack_o),
      .rvalid_o         (rvalid_o),
      .rdata_o          (rdata_o)
   );

   task automatic drive(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic sr = 1'b1);
      @(posedge clk_i);
      #1;
      req_i = r; we_i = w; addr_i = a; wdata_i = d; be_i = b; set_retentive_ni = sr;
      @(negedge clk_i);
      cyc++;
   endtask

   function automatic void model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
      for (int i = 0; i < 4; i++) if (b[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk_i);
      checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
      checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
      checks++; if (ret_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ret_ack got=%b exp=0", ret_ack_o); end
      @(posedge clk_i); #1; rst_ni = 1'b1;
      drive(1'b1, 1'b1, 12'd7, 32'h0BADF00D, 4'hF);
      model_write(12'd7, 32'h0BADF00D, 4'hF);
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL reset_first_gnt got=%b exp=1", gnt_o); end
      drive(1'b1, 1'b0, 12'd7, '0, '0);
      drive(1'b0, 1'b0, 12'd0, '0, '0);
      drive(1'b0, 1'b0, 12'd0, '0, '0);
      checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0BADF00D) begin
         errors++; $display("FAIL reset_first_read got=%b/%h exp=1/0badf00d", rvalid_o, rdata_o); end
      last_rd = 32'h0BADF00D;
   endtask

   task automatic test_single_rw();
      drive(1'b1, 1'b1, 12'd5, 32'hDEADBEEF, 4'hF);
      model_write(12'd5, 32'hDEADBEEF, 4'hF);
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rw_wr_gnt got=%b exp=1", gnt_o); end
      drive(1'b1, 1'b0, 12'd5, '0, '0);
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rw_rd_gnt got=%b exp=1", gnt_o); end
      drive(1'b0, 1'b0, 12'd0, '0, '0);
      checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rw_early_rvalid got=%b exp=0", rvalid_o); end
      drive(1'b0, 1'b0, 12'd0, '0, '0);
      checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rw_read got=%b/%h exp=1/deadbeef", rvalid_o, rdata_o); end
      drive(1'b0, 1'b0, 12'd0, '0, '0);
      checks++; if (rvalid_o !== 1'b0 || rdata_o !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rw_hold got=%b/%h exp=0/deadbeef", rvalid_o, rdata_o); end
      last_rd = 32'hDEADBEEF;
   endtask

   task automatic test_byte_en();
      drive(1'b1, 1'b1, 12'd6, 32'h11223344, 4'hF);
      drive(1'b1, 1'b1, 12'd6, 32'hAABBCCDD, 4'h5);
      drive(1'b1, 1'b1, 12'd6, 32'hFFFFFFFF, 4'h0);
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL be_zero_gnt got=%b exp=1", gnt_o); end
      model_write(12'd6, 32'h11BB33DD, 4'hF);
      drive(1'b1, 1'b0, 12'd6, '0, '0);
      drive(1'b0, 1'b0, 12'd0, '0, '0);
      drive(1'b0, 1'b0, 12'd0, '0, '0);
      checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h11BB33DD) begin
         errors++; $display("FAIL be_merge got=%b/%h exp=1/11bb33dd", rvalid_o, rdata_o); end
      last_rd = 32'h11BB33DD;
   endtask

   task automatic test_back_to_back();
      logic [31:0] v [4];
      for (int i = 0; i < 4; i++) begin
         v[i] = $urandom;
         drive(1'b1, 1'b1, 12'(i), v[i], 4'hF);
         model_write(12'(i), v[i], 4'hF);
      end
      for (int k = 0; k < 7; k++) begin
         drive(k < 4, 1'b0, 12'(k), '0, '0);
         if (k < 4) begin
            checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", k, gnt_o); end
         end
         checks++; if (rvalid_o !== (k >= 2 && k < 6)) begin
            errors++; $display("FAIL b2b_rvalid[%0d] got=%b exp=%b", k, rvalid_o, (k >= 2 && k < 6)); end
         if (k >= 2 && k < 6) begin
            checks++; if (rdata_o !== v[k-2]) begin
               errors++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", k, rdata_o, v[k-2]); end
         end
      end
      last_rd = v[3];
   endtask

   task automatic test_retention();
      int g;
      logic seen_rv = 1'b0;
      logic acked = 1'b0;
      drive(1'b1, 1'b0, 12'd5, '0, '0);
      g = cyc;
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL ret_pre_gnt got=%b exp=1", gnt_o); end
      for (int k = 0; k < 10 && !acked; k++) begin
         drive(1'b1, 1'b0, 12'd5, '0, '0, 1'b0);
         checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL ret_drain_gnt got=%b exp=0", gnt_o); end
         if (rvalid_o) begin
            seen_rv = 1'b1;
            checks++; if (rdata_o !== ref_mem[5] || cyc != g + 2) begin
               errors++; $display("FAIL ret_drain_read got=%h@%0d exp=%h@%0d", rdata_o, cyc, ref_mem[5], g + 2); end
         end
         if (ret_ack_o) begin
            acked = 1'b1;
            checks++; if (!seen_rv) begin errors++; $display("FAIL ret_order got=ack_before_rvalid exp=rvalid_first"); end
         end
      end
      checks++; if (!acked) begin errors++; $display("FAIL ret_ack_timeout got=0 exp=1"); end
      last_rd = ref_mem[5];
      repeat (3) begin
         drive(1'b1, 1'b0, 12'd5, '0, '0, 1'b0);
         checks++; if (ret_ack_o !== 1'b1 || gnt_o !== 1'b0) begin
            errors++; $display("FAIL ret_hold got=%b/%b exp=1/0", ret_ack_o, gnt_o); end
      end
      drive(1'b1, 1'b0, 12'd5, '0, '0, 1'b1);
      checks++; if (ret_ack_o !== 1'b1 || gnt_o !== 1'b0) begin
         errors++; $display("FAIL ret_release got=%b/%b exp=1/0", ret_ack_o, gnt_o); end
      for (int k = 1; k <= 7; k++) begin
         drive(k <= 5, 1'b0, 12'd5, '0, '0, 1'b1);
         checks++; if (ret_ack_o !== 1'b0) begin errors++; $display("FAIL wake_ack[%0d] got=%b exp=0", k, ret_ack_o); end
         checks++; if (gnt_o !== (k == 5)) begin errors++; $display("FAIL wake_gnt[%0d] got=%b exp=%b", k, gnt_o, (k == 5)); end
         checks++; if (rvalid_o !== (k == 7)) begin errors++; $display("FAIL wake_rvalid[%0d] got=%b exp=%b", k, rvalid_o, (k == 7)); end
      end
      checks++; if (rdata_o !== ref_mem[5]) begin errors++; $display("FAIL wake_data got=%h exp=%h", rdata_o, ref_mem[5]); end
   endtask

   task automatic test_wake_abort();
      drive(1'b0, 1'b0, 12'd0, '0, '0, 1'b0);
      drive(1'b0, 1'b0, 12'd0, '0, '0, 1'b0);
      checks++; if (ret_ack_o !== 1'b1) begin errors++; $display("FAIL abort_enter got=%b exp=1", ret_ack_o); end
      drive(1'b1, 1'b0, 12'd6, '0, '0, 1'b1);
      drive(1'b1, 1'b0, 12'd6, '0, '0, 1'b0);
      checks++; if (ret_ack_o !== 1'b0 || gnt_o !== 1'b0) begin
         errors++; $display("FAIL abort_wake got=%b/%b exp=0/0", ret_ack_o, gnt_o); end
      drive(1'b1, 1'b0, 12'd6, '0, '0, 1'b0);
      checks++; if (ret_ack_o !== 1'b1 || gnt_o !== 1'b0) begin
         errors++; $display("FAIL abort_back got=%b/%b exp=1/0", ret_ack_o, gnt_o); end
      drive(1'b1, 1'b0, 12'd6, '0, '0, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         drive(k <= 5, 1'b0, 12'd6, '0, '0, 1'b1);
         checks++; if (gnt_o !== (k == 5)) begin errors++; $display("FAIL abort_gnt[%0d] got=%b exp=%b", k, gnt_o, (k == 5)); end
      end
      checks++; if (rvalid_o !== 1'b1 || rdata_o !== ref_mem[6]) begin
         errors++; $display("FAIL abort_data got=%b/%h exp=1/%h", rvalid_o, rdata_o, ref_mem[6]); end
      last_rd = ref_mem[6];
   endtask

   task automatic test_random();
      int due_q[$];
      logic [31:0] dat_q[$];
      logic r, w, exp_v;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0] b;
      for (int i = 0; i < 32; i++) begin
         d = $urandom;
         drive(1'b1, 1'b1, 12'(i), d, 4'hF);
         model_write(12'(i), d, 4'hF);
      end
      for (int n = 0; n < 303; n++) begin
         r = (n < 300) && ($urandom_range(0, 3) != 0);
         w = ($urandom_range(0, 1) == 1);
         a = 12'($urandom_range(0, 31));
         d = $urandom;
         b = 4'($urandom_range(0, 15));
         drive(r, w, a, d, b);
         checks++; if (gnt_o !== r) begin errors++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", n, gnt_o, r); end
         exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
         checks++; if (rvalid_o !== exp_v) begin errors++; $display("FAIL rnd_rvalid[%0d] got=%b exp=%b", n, rvalid_o, exp_v); end
         if (exp_v) begin
            last_rd = dat_q.pop_front();
            void'(due_q.pop_front());
         end
         checks++; if (rdata_o !== last_rd) begin errors++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, rdata_o, last_rd); end
         if (r && w) model_write(a, d, b);
         else if (r) begin
            due_q.push_back(cyc + 2);
            dat_q.push_back(ref_mem[a]);
         end
      end
   endtask

   task automatic test_reset_inflight();
      drive(1'b1, 1'b0, 12'd1, '0, '0);
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rst_rd0_gnt got=%b exp=1", gnt_o); end
      drive(1'b1, 1'b0, 12'd2, '0, '0);
      checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rst_rd1_gnt got=%b exp=1", gnt_o); end
      @(posedge clk_i); #1;
      req_i = 1'b0;
      rst_ni = 1'b0;
      @(negedge clk_i);
      checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_during got=%b exp=0", rvalid_o); end
      @(posedge clk_i); #1; rst_ni = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 12'd0, '0, '0);
         checks++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++; $display("FAIL rst_after[%0d] got=%b/%h exp=0/0", k, rvalid_o, rdata_o); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_rw();
      test_byte_en();
      test_back_to_back();
      test_retention();
      test_wake_abort();
      test_random();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
